// File: rtl/rv32_pkg.sv
// Shared RV32I decode definitions: opcodes, immediate formats and the
// immediate-generation helper used by the decode stage.
package rv32_pkg;

    localparam int XLEN = 32;
    localparam int PC_W = 12;
    localparam int NREG = 32;

    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_IMM    = 7'b0010011;
    localparam logic [6:0] OP_JALR   = 7'b1100111;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_LUI    = 7'b0110111;
    localparam logic [6:0] OP_AUIPC  = 7'b0010111;
    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_REG    = 7'b0110011;

    typedef enum logic [2:0] {
        IMM_I,
        IMM_S,
        IMM_B,
        IMM_U,
        IMM_J,
        IMM_NONE
    } imm_type_e;

    function automatic imm_type_e imm_type_of(input logic [6:0] op);
        imm_type_e t;
        case (op)
            OP_LOAD, OP_IMM, OP_JALR: t = IMM_I;
            OP_STORE:                 t = IMM_S;
            OP_BRANCH:                t = IMM_B;
            OP_LUI, OP_AUIPC:         t = IMM_U;
            OP_JAL:                   t = IMM_J;
            default:                  t = IMM_NONE;
        endcase
        return t;
    endfunction

    function automatic logic op_legal(input logic [6:0] op);
        return (op == OP_LOAD)  || (op == OP_IMM)    || (op == OP_JALR) ||
               (op == OP_STORE) || (op == OP_BRANCH) || (op == OP_LUI)  ||
               (op == OP_AUIPC) || (op == OP_JAL)    || (op == OP_REG);
    endfunction

    // Only the non-opcode bits are taken; the format is already resolved.
    function automatic logic [31:0] gen_imm(input logic [31:7] ins, input imm_type_e t);
        logic [31:0] imm;
        case (t)
            IMM_I:   imm = {{20{ins[31]}}, ins[31:20]};
            IMM_S:   imm = {{20{ins[31]}}, ins[31:25], ins[11:7]};
            IMM_B:   imm = {{19{ins[31]}}, ins[31], ins[7], ins[30:25], ins[11:8], 1'b0};
            IMM_U:   imm = {ins[31:12], 12'b0};
            IMM_J:   imm = {{11{ins[31]}}, ins[31], ins[19:12], ins[20], ins[30:21], 1'b0};
            default: imm = '0;
        endcase
        return imm;
    endfunction

endpackage

// File: rtl/regfile_2r1w.sv
// 2-read/1-write register file, x0 hardwired to zero, with write-through
// bypass so a same-cycle read of the register being written sees new data.
module regfile_2r1w
    import rv32_pkg::*;
#(
    parameter int W  = 32,
    parameter int NR = 32,
    parameter int AW = $clog2(NR)
) (
    input  logic          i_clk,
    input  logic          i_rst_n,
    input  logic          i_we,
    input  logic [AW-1:0] i_wa,
    input  logic [W-1:0]  i_wd,
    input  logic [AW-1:0] i_ra1,
    input  logic [AW-1:0] i_ra2,
    output logic [W-1:0]  o_rd1,
    output logic [W-1:0]  o_rd2
);

    logic [NR-1:0][W-1:0] r_mem;
    logic                 w_wr;

    assign w_wr = i_we && (i_wa != '0);

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n)
            r_mem <= '0;
        else if (w_wr)
            r_mem[i_wa] <= i_wd;
    end

    assign o_rd1 = (i_ra1 == '0)             ? '0   :
                   (w_wr && i_wa == i_ra1)   ? i_wd : r_mem[i_ra1];
    assign o_rd2 = (i_ra2 == '0)             ? '0   :
                   (w_wr && i_wa == i_ra2)   ? i_wd : r_mem[i_ra2];

endmodule

// File: rtl/decode_stage.sv
// RV32I decode stage: registers the decoded fetch bundle for execute, with
// stall (hold plus operand refresh from writeback) and flush (kill).
module decode_stage
    import rv32_pkg::*;
#(
    parameter int PC_W = rv32_pkg::PC_W,
    parameter int XLEN = rv32_pkg::XLEN,
    parameter int NREG = rv32_pkg::NREG
) (
    input  logic            i_clk,
    input  logic            i_rst_n,
    input  logic            i_if_valid,
    input  logic [PC_W-1:0] i_if_pc,
    input  logic [31:0]     i_if_instr,
    output logic            o_if_ready,
    input  logic            i_id_stall,
    input  logic            i_id_flush,
    input  logic            i_wb_we,
    input  logic [4:0]      i_wb_rd,
    input  logic [XLEN-1:0] i_wb_data,
    output logic            o_id_valid,
    output logic [PC_W-1:0] o_id_pc,
    output logic [6:0]      o_id_opcode,
    output logic [4:0]      o_id_rd,
    output logic [4:0]      o_id_rs1,
    output logic [4:0]      o_id_rs2,
    output logic [2:0]      o_id_funct3,
    output logic [6:0]      o_id_funct7,
    output logic [XLEN-1:0] o_id_imm,
    output logic [XLEN-1:0] o_id_rs1_data,
    output logic [XLEN-1:0] o_id_rs2_data,
    output logic            o_id_illegal
);

    logic [6:0]      w_opcode;
    logic [4:0]      w_rs1, w_rs2;
    logic            w_legal;
    logic [XLEN-1:0] w_imm, w_rd1, w_rd2;
    logic            w_wb_hit;

    logic            r_valid;
    logic [PC_W-1:0] r_pc;
    logic [6:0]      r_opcode;
    logic [4:0]      r_rd, r_rs1, r_rs2;
    logic [2:0]      r_funct3;
    logic [6:0]      r_funct7;
    logic [XLEN-1:0] r_imm, r_rs1_data, r_rs2_data;
    logic            r_illegal;

    assign w_opcode = i_if_instr[6:0];
    assign w_rs1    = i_if_instr[19:15];
    assign w_rs2    = i_if_instr[24:20];
    assign w_legal  = (i_if_instr[1:0] == 2'b11) && op_legal(w_opcode);
    assign w_imm    = w_legal ? XLEN'(gen_imm(i_if_instr[31:7], imm_type_of(w_opcode))) : '0;
    assign w_wb_hit = i_wb_we && (i_wb_rd != 5'd0);

    regfile_2r1w #(.W(XLEN), .NR(NREG), .AW(5)) u_rf (
        .i_clk   (i_clk),
        .i_rst_n (i_rst_n),
        .i_we    (i_wb_we),
        .i_wa    (i_wb_rd),
        .i_wd    (i_wb_data),
        .i_ra1   (w_rs1),
        .i_ra2   (w_rs2),
        .o_rd1   (w_rd1),
        .o_rd2   (w_rd2)
    );

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_valid    <= 1'b0;
            r_pc       <= '0;
            r_opcode   <= '0;
            r_rd       <= '0;
            r_rs1      <= '0;
            r_rs2      <= '0;
            r_funct3   <= '0;
            r_funct7   <= '0;
            r_imm      <= '0;
            r_rs1_data <= '0;
            r_rs2_data <= '0;
            r_illegal  <= 1'b0;
        end else if (i_id_flush) begin
            r_valid <= 1'b0;
        end else if (i_id_stall) begin
            // Held operands track writeback so execute never sees stale data.
            if (r_valid && w_wb_hit) begin
                if (i_wb_rd == r_rs1) r_rs1_data <= i_wb_data;
                if (i_wb_rd == r_rs2) r_rs2_data <= i_wb_data;
            end
        end else begin
            r_valid    <= i_if_valid;
            r_pc       <= i_if_pc;
            r_opcode   <= w_opcode;
            r_rd       <= i_if_instr[11:7];
            r_rs1      <= w_rs1;
            r_rs2      <= w_rs2;
            r_funct3   <= i_if_instr[14:12];
            r_funct7   <= i_if_instr[31:25];
            r_imm      <= w_imm;
            r_rs1_data <= w_rd1;
            r_rs2_data <= w_rd2;
            r_illegal  <= !w_legal;
        end
    end

    assign o_if_ready    = !i_id_stall;
    assign o_id_valid    = r_valid;
    assign o_id_pc       = r_pc;
    assign o_id_opcode   = r_opcode;
    assign o_id_rd       = r_rd;
    assign o_id_rs1      = r_rs1;
    assign o_id_rs2      = r_rs2;
    assign o_id_funct3   = r_funct3;
    assign o_id_funct7   = r_funct7;
    assign o_id_imm      = r_imm;
    assign o_id_rs1_data = r_rs1_data;
    assign o_id_rs2_data = r_rs2_data;
    assign o_id_illegal  = r_illegal;

endmodule

// File: tb/tb_decode_stage.sv
// Directed plus randomized bench for decode_stage, checked against a
// bundle-level reference model of the decode stage and register file.
module tb_decode_stage;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        if_valid, if_ready, id_stall, id_flush, wb_we;
    logic [11:0] if_pc;
    logic [31:0] if_instr, wb_data;
    logic [4:0]  wb_rd;
    logic        id_valid, id_illegal;
    logic [11:0] id_pc;
    logic [6:0]  id_opcode, id_funct7;
    logic [4:0]  id_rd, id_rs1, id_rs2;
    logic [2:0]  id_funct3;
    logic [31:0] id_imm, id_rs1_data, id_rs2_data;

    int total = 0;
    int bad   = 0;

    typedef struct {
        logic        v;
        logic [11:0] pc;
        logic [6:0]  op;
        logic [4:0]  rd, rs1, rs2;
        logic [2:0]  f3;
        logic [6:0]  f7;
        logic [31:0] imm, d1, d2;
        logic        ill;
    } bund_t;

    bund_t       exp_b;
    logic [31:0] rf [32];
    logic [6:0]  legal_ops [9] = '{7'h03, 7'h13, 7'h67, 7'h23, 7'h63, 7'h37, 7'h17, 7'h6F, 7'h33};

    always #5 clk = ~clk;

    decode_stage dut (
        .i_clk(clk), .i_rst_n(rst_n),
        .i_if_valid(if_valid), .i_if_pc(if_pc), .i_if_instr(if_instr), .o_if_ready(if_ready),
        .i_id_stall(id_stall), .i_id_flush(id_flush),
        .i_wb_we(wb_we), .i_wb_rd(wb_rd), .i_wb_data(wb_data),
        .o_id_valid(id_valid), .o_id_pc(id_pc), .o_id_opcode(id_opcode),
        .o_id_rd(id_rd), .o_id_rs1(id_rs1), .o_id_rs2(id_rs2),
        .o_id_funct3(id_funct3), .o_id_funct7(id_funct7), .o_id_imm(id_imm),
        .o_id_rs1_data(id_rs1_data), .o_id_rs2_data(id_rs2_data), .o_id_illegal(id_illegal)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] expv);
        total++;
        assert (got === expv) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, got, expv);
        end
    endtask

    // Immediate assembled arithmetically from the ISA field layout.
    function automatic logic [31:0] ref_imm(input logic [31:0] i);
        logic [31:0] s;
        s = i[31] ? 32'hFFFF_FFFF : 32'h0;
        case (i[6:0])
            7'h03, 7'h13, 7'h67: return (s << 12) | 32'(i[31:20]);
            7'h23:               return (s << 12) | (32'(i[31:25]) << 5) | 32'(i[11:7]);
            7'h63:               return (s << 12) | (32'(i[7]) << 11) | (32'(i[30:25]) << 5) | (32'(i[11:8]) << 1);
            7'h37, 7'h17:        return i & 32'hFFFF_F000;
            7'h6F:               return (s << 20) | (32'(i[19:12]) << 12) | (32'(i[20]) << 11) | (32'(i[30:21]) << 1);
            default:             return 32'h0;
        endcase
    endfunction

    function automatic logic is_legal(input logic [31:0] i);
        foreach (legal_ops[k]) if (i[6:0] == legal_ops[k]) return 1'b1;
        return 1'b0;
    endfunction

    function automatic logic [31:0] rf_read(input logic [4:0] r);
        if (r == 0) return 32'h0;
        if (wb_we && wb_rd == r) return wb_data;
        return rf[r];
    endfunction

    task automatic model_reset();
        exp_b = '{v: 1'b0, pc: '0, op: '0, rd: '0, rs1: '0, rs2: '0, f3: '0, f7: '0,
                  imm: '0, d1: '0, d2: '0, ill: 1'b0};
        foreach (rf[k]) rf[k] = 32'h0;
    endtask

    task automatic check_all();
        chk("if_ready", 32'(if_ready), 32'(!id_stall));
        chk("valid", 32'(id_valid), 32'(exp_b.v));
        if (exp_b.v) begin
            chk("pc", 32'(id_pc), 32'(exp_b.pc));
            chk("opcode", 32'(id_opcode), 32'(exp_b.op));
            chk("rd", 32'(id_rd), 32'(exp_b.rd));
            chk("rs1", 32'(id_rs1), 32'(exp_b.rs1));
            chk("rs2", 32'(id_rs2), 32'(exp_b.rs2));
            chk("funct3", 32'(id_funct3), 32'(exp_b.f3));
            chk("funct7", 32'(id_funct7), 32'(exp_b.f7));
            chk("imm", id_imm, exp_b.imm);
            chk("rs1_data", id_rs1_data, exp_b.d1);
            chk("rs2_data", id_rs2_data, exp_b.d2);
            chk("illegal", 32'(id_illegal), 32'(exp_b.ill));
        end
    endtask

    // Predict the next bundle from the current inputs, clock, then compare.
    task automatic tick();
        bund_t n;
        n = exp_b;
        if (id_flush) begin
            n.v = 1'b0;
        end else if (id_stall) begin
            if (exp_b.v && wb_we && wb_rd != 0) begin
                if (wb_rd == exp_b.rs1) n.d1 = wb_data;
                if (wb_rd == exp_b.rs2) n.d2 = wb_data;
            end
        end else begin
            n.v   = if_valid;
            n.pc  = if_pc;
            n.op  = if_instr[6:0];
            n.rd  = if_instr[11:7];
            n.rs1 = if_instr[19:15];
            n.rs2 = if_instr[24:20];
            n.f3  = if_instr[14:12];
            n.f7  = if_instr[31:25];
            n.ill = !is_legal(if_instr);
            n.imm = n.ill ? 32'h0 : ref_imm(if_instr);
            n.d1  = rf_read(n.rs1);
            n.d2  = rf_read(n.rs2);
        end
        if (wb_we && wb_rd != 0) rf[wb_rd] = wb_data;
        @(posedge clk);
        #1;
        exp_b = n;
        check_all();
    endtask

    task automatic drive(input logic v, input logic [11:0] pc, input logic [31:0] ins);
        if_valid = v; if_pc = pc; if_instr = ins;
    endtask

    task automatic wb(input logic we, input logic [4:0] rd, input logic [31:0] d);
        wb_we = we; wb_rd = rd; wb_data = d;
    endtask

    initial begin
        rst_n = 1'b0;
        drive(1'b0, 12'h0, 32'h0);
        wb(1'b0, 5'd0, 32'h0);
        id_stall = 1'b0; id_flush = 1'b0;
        model_reset();
        #22;
        chk("reset_valid", 32'(id_valid), 32'h0);
        chk("reset_imm", id_imm, 32'h0);
        rst_n = 1'b1;
        @(posedge clk); #1;

        // addi x12,x0,5 while writeback installs x12=5
        drive(1'b1, 12'h000, 32'h0050_0613);
        wb(1'b1, 5'd12, 32'h5);
        tick();
        chk("addi_rd", 32'(id_rd), 32'd12);
        chk("addi_imm", id_imm, 32'd5);
        chk("addi_rs1_data", id_rs1_data, 32'd0);
        chk("addi_illegal", 32'(id_illegal), 32'd0);

        // sw x12,4(x0)
        wb(1'b0, 5'd0, 32'h0);
        drive(1'b1, 12'h004, 32'h00C0_2223);
        tick();
        chk("sw_opcode", 32'(id_opcode), 32'h23);
        chk("sw_funct3", 32'(id_funct3), 32'd2);
        chk("sw_imm", id_imm, 32'd4);
        chk("sw_rs2_data", id_rs2_data, 32'd5);

        // beq x0,x0,-4 and an illegal encoding
        drive(1'b1, 12'h008, 32'hFE00_0EE3);
        tick();
        chk("beq_imm", id_imm, 32'hFFFF_FFFC);
        drive(1'b1, 12'h00C, 32'h0000_00FF);
        tick();
        chk("ill_flag", 32'(id_illegal), 32'd1);
        chk("ill_imm", id_imm, 32'h0);

        // add x15,x12,x12 with same-cycle writeback of x12
        drive(1'b1, 12'h010, 32'h00C6_07B3);
        wb(1'b1, 5'd12, 32'h1234);
        tick();
        chk("byp_rs1", id_rs1_data, 32'h1234);
        chk("byp_rs2", id_rs2_data, 32'h1234);

        // write to x0 is ignored: addi x1,x0,0 reads x0
        drive(1'b1, 12'h014, 32'h0000_0093);
        wb(1'b1, 5'd0, 32'h7);
        tick();
        chk("x0_read", id_rs1_data, 32'h0);

        // stall with operand refresh on cycle 2
        wb(1'b0, 5'd0, 32'h0);
        drive(1'b1, 12'h018, 32'h00C6_07B3);
        tick();
        id_stall = 1'b1;
        drive(1'b1, 12'h01C, 32'h0050_0613);
        tick();
        wb(1'b1, 5'd12, 32'hAA);
        tick();
        wb(1'b0, 5'd0, 32'h0);
        tick();
        chk("stall_pc", 32'(id_pc), 32'h018);
        chk("stall_refresh", id_rs1_data, 32'hAA);
        chk("stall_ready", 32'(if_ready), 32'h0);

        // flush wins over stall
        id_flush = 1'b1;
        tick();
        chk("flush_valid", 32'(id_valid), 32'h0);
        id_flush = 1'b0; id_stall = 1'b0;
        tick();

        // async reset mid-cycle discards everything
        #3;
        rst_n = 1'b0;
        #1;
        model_reset();
        chk("areset_valid", 32'(id_valid), 32'h0);
        chk("areset_pc", 32'(id_pc), 32'h0);
        chk("areset_rs1_data", id_rs1_data, 32'h0);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk); #1;
        drive(1'b1, 12'h020, 32'h00C6_07B3);
        tick();
        chk("post_reset_x12", id_rs1_data, 32'h0);

        // randomized traffic
        for (int c = 0; c < 1500; c++) begin
            logic [31:0] ins;
            ins = $urandom;
            if ($urandom_range(0, 9) < 8) ins[6:0] = legal_ops[$urandom_range(0, 8)];
            drive($urandom_range(0, 3) != 0, 12'($urandom), ins);
            id_stall = ($urandom_range(0, 3) == 0);
            id_flush = ($urandom_range(0, 9) == 0);
            wb($urandom_range(0, 1) == 1, 5'($urandom), $urandom);
            tick();
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/decode_stage.md
Name: decode_stage

Overview:
- RV32I decode stage; sits directly downstream of the fetch stage (instruction memory + PC increment).
- Accepts {pc, instr} from fetch, decodes fields and immediates, and reads operands from an internal 32x32 register file with a writeback write port.
- Presents a registered decode bundle to execute with 1-cycle latency.
- Supports stall (hold) and flush (kill).

Parameters:
- PC_W, 12, width of program counter (matches 4 KiB byte-addressed instruction memory)
- XLEN, 32, register and data width
- NREG, 32, architectural registers (x0 hardwired zero)

Ports:
- clk  in  1  clock, all state updates on rising edge
- rst_n  in  1  reset, asynchronous and active-low
- if_valid  in  1  fetch bundle valid this cycle
- if_pc  in  PC_W  PC of fetched instruction
- if_instr  in  32  fetched instruction, little-endian assembled
- if_ready  out  1  decode can accept; = !id_stall (combinational)
- id_stall  in  1  execute back-pressure; hold all id_* outputs
- id_flush  in  1  kill: invalidate stage contents next edge
- wb_we  in  1  writeback enable
- wb_rd  in  5  writeback destination
- wb_data  in  XLEN  writeback data
- id_valid  out  1  decode bundle valid
- id_pc  out  PC_W  PC of decoded instruction
- id_opcode  out  7  instr[6:0]
- id_rd, id_rs1, id_rs2  out  5 each  register indices
- id_funct3  out  3  instr[14:12]
- id_funct7  out  7  instr[31:25]
- id_imm  out  XLEN  sign-extended immediate
- id_rs1_data, id_rs2_data  out  XLEN  operand values
- id_illegal  out  1  unsupported/illegal encoding

Behaviour:
- Reset (rst_n=0, asynchronous): all id_* outputs = 0; all registers x0..x31 = 0. Outputs remain 0 until the first rising edge after rst_n deasserts. Reset mid-stall or mid-flush discards everything.
- Latency: 1 cycle. Bundle sampled at edge N appears on id_* after edge N.
- Edge priority, highest first:
  - id_flush=1: id_valid<=0; other id_* are don't-care, implement as hold.
  - id_stall=1: hold all id_* outputs. Exception: operand refresh (below).
  - Otherwise: latch decode of if_*; id_valid<=if_valid.
- Flush and stall together: flush wins.
- if_valid=0 with no stall/flush: id_valid<=0. Fields may update (don't-care).
- Immediate by opcode, all sign-extended from instr[31]:
  - I-type (0000011, 0010011, 1100111): instr[31:20].
  - S-type (0100011): {instr[31:25], instr[11:7]}.
  - B-type (1100011): {instr[31], instr[7], instr[30:25], instr[11:8], 0}.
  - U-type (0110111, 0010111): {instr[31:12], 12'b0}.
  - J-type (1101111): {instr[31], instr[19:12], instr[20], instr[30:21], 0}.
  - R-type (0110011): imm=0.
- Illegal: instr[1:0]!=2'b11 or opcode not in the list above → id_illegal=1, id_imm=0. id_valid still follows if_valid; execute traps.
- Register file:
  - 2 combinational read ports, 1 write port. Write on rising edge when wb_we && wb_rd!=0.
  - Writes to x0 are ignored; reads of x0 return 0.
- Write-through bypass: a read of rs (rs!=0) with wb_we && wb_rd==rs in the same cycle returns wb_data, not the stale value.
- Operand refresh during stall: while id_stall=1 and id_valid=1, if wb_we && wb_rd!=0 && wb_rd==id_rs1, then id_rs1_data<=wb_data. Same rule for id_rs2. This prevents holding stale operands across a stall.
- Simultaneous write and decode of the same register: the bypass gives the new value. The register-file update lands on the same edge.

Decomposition:
- Package rv32_pkg:
  - opcode localparams: OP_LOAD, OP_IMM, OP_JALR, OP_STORE, OP_BRANCH, OP_LUI, OP_AUIPC, OP_JAL, OP_REG.
  - imm_type enum {IMM_I, IMM_S, IMM_B, IMM_U, IMM_J, IMM_NONE}.
  - XLEN, PC_W.
- Sub-module regfile_2r1w: asynchronous-reset storage, x0 forced zero, write-through bypass.
- Immediate generation is a function in the package.

Test Plan:
- Reset then if_valid=1, pc=0, instr=0x00500613 (addi x12,x0,5) → next cycle id_valid=1, id_rd=12, id_rs1=0, id_imm=5, id_rs1_data=0, id_illegal=0.
- instr=0x00C02223 (sw x12,4(x0)) with x12=5 previously written → id_opcode=0x23, id_funct3=2, id_rs2=12, id_imm=4, id_rs2_data=5.
- instr=0xFE000EE3 (beq x0,x0,-4) → id_imm=0xFFFFFFFC. Also instr=0x000000FF → id_illegal=1, id_imm=0.
- Same-cycle bypass: decode add x15,x12,x12 while wb_we=1, wb_rd=12, wb_data=0x1234 → id_rs1_data=id_rs2_data=0x1234. Separately, wb_rd=0, wb_data=7 → x0 still reads 0.
- Stall hold/refresh: hold id_stall=1 for 3 cycles with id_rs1=12; write x12=0xAA on cycle 2 → all fields constant except id_rs1_data, which becomes 0xAA. if_ready=0 throughout.
- Flush+stall together with id_valid=1 → id_valid=0 next cycle. Then assert rst_n=0 asynchronously mid-cycle → all outputs 0 immediately, and x12 reads 0 afterwards.
